// File: rtl/uart_pkg.sv
// Shared constants, state encoding and timeout sizing for the UART command controller.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_RDCAP,
        ST_RESP
    } state_t;

    // One UART character is 10 bit times (start + 8 data + stop).
    function automatic int unsigned to_cycles(input int unsigned clk_freq,
                                              input int unsigned baud_rate,
                                              input int unsigned timeout_bytes);
        return (clk_freq / baud_rate) * 10 * timeout_bytes;
    endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// Inter-byte idle counter: expire_o pulses combinationally on the cycle the count sits at TO_CYCLES-1.
// Held at zero while disabled; a clear in the expiry cycle suppresses the pulse.
module uart_timeout_ctr #(
    parameter int unsigned TO_CYCLES = 4320
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command decoder: SYNC CMD ADDR [DATA] CHK -> one register access -> one response byte.
// EXEC one cycle after CHK byte; tx_valid held until tx_ready, bytes arriving in EXEC/RESP are dropped.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned BAUD_RATE     = 921_600,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter int unsigned ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wr_data,
    input  logic [7:0]        reg_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int unsigned TO_CYCLES = to_cycles(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);

    state_t            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        err_q, err_d;
    logic              err_inc;
    logic              tmo_en, tmo_expire;

    assign tmo_en = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                    (state_q == ST_DATA) || (state_q == ST_CHK);

    uart_timeout_ctr #(.TO_CYCLES(TO_CYCLES)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .en_i     (tmo_en),
        .clr_i    (rx_done),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        chk_d     = chk_q;
        tx_data_d = tx_data_q;
        err_inc   = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_done && rx_data == SYNC_BYTE) begin
                chk_d   = '0;
                state_d = ST_CMD;
            end
            ST_CMD: if (rx_done) begin
                if (rx_data == OP_WR || rx_data == OP_RD) begin
                    is_wr_d = (rx_data == OP_WR);
                    chk_d   = chk_q ^ rx_data;
                    state_d = ST_ADDR;
                end else begin
                    tx_data_d = NAK;
                    err_inc   = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_ADDR: if (rx_done) begin
                addr_d  = ADDR_W'(rx_data);
                chk_d   = chk_q ^ rx_data;
                state_d = is_wr_q ? ST_DATA : ST_CHK;
            end
            ST_DATA: if (rx_done) begin
                data_d  = rx_data;
                chk_d   = chk_q ^ rx_data;
                state_d = ST_CHK;
            end
            ST_CHK: if (rx_done) begin
                if (rx_data == chk_q) begin
                    state_d = ST_EXEC;
                end else begin
                    tx_data_d = NAK;
                    err_inc   = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_EXEC: begin
                if (is_wr_q) begin
                    tx_data_d = ACK;
                    state_d   = ST_RESP;
                end else begin
                    state_d = ST_RDCAP;
                end
            end
            // Read data is valid exactly one cycle after the read strobe.
            ST_RDCAP: begin
                tx_data_d = reg_rd_data;
                state_d   = ST_RESP;
            end
            ST_RESP: if (tx_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Expiry is already masked by rx_done, so a byte in the expiry cycle is consumed above.
        if (tmo_expire) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
        end
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            chk_q     <= '0;
            tx_data_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    assign reg_wr_en   = (state_q == ST_EXEC) && is_wr_q;
    assign reg_rd_en   = (state_q == ST_EXEC) && !is_wr_q;
    assign reg_addr    = addr_q;
    assign reg_wr_data = data_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = (state_q == ST_RESP);
    assign busy        = (state_q != ST_IDLE);
    assign err_count   = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected bus/tx events, a monitor pops and compares.
module tb_uart_cmd_ctrl;

    localparam int TO = 4320;
    localparam int K_WR = 0, K_RD = 1, K_TX = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       reg_wr_en, reg_rd_en;
    logic [7:0] reg_addr, reg_wr_data;
    logic [7:0] reg_rd_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic [7:0] err_count;
    logic [7:0] rd_val = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_count   (err_count)
    );

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic void push(input int kind, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void pop_cmp(input int kind, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", kind, 99);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", kind, e.kind);
            check("evt_addr", addr, e.addr);
            check("evt_data", data, e.data);
        end
    endfunction

    // Read responder: data appears the cycle after the read strobe, zero otherwise.
    initial begin
        logic last_rd;
        last_rd = 1'b0;
        forever begin
            @(negedge clk);
            reg_rd_data = last_rd ? rd_val : 8'h00;
            last_rd = reg_rd_en;
        end
    end

    // Monitor: samples between edges, compares every DUT event against the scoreboard.
    initial begin
        int cyc, exec_cyc, exp_lat;
        bit pend, prev_v;
        cyc = 0; exec_cyc = 0; exp_lat = 0; pend = 0; prev_v = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (reset) begin
                pend = 0;
            end else begin
                if (reg_wr_en && reg_rd_en) check("strobe_exclusive", 1, 0);
                if (reg_wr_en) begin
                    pend = 1; exec_cyc = cyc; exp_lat = 1;
                    pop_cmp(K_WR, reg_addr, reg_wr_data);
                end else if (reg_rd_en) begin
                    pend = 1; exec_cyc = cyc; exp_lat = 2;
                    pop_cmp(K_RD, reg_addr, 8'h00);
                end
                if (tx_valid && !prev_v && pend) begin
                    check("tx_latency", cyc - exec_cyc, exp_lat);
                    pend = 0;
                end
                if (tx_valid && tx_ready) pop_cmp(K_TX, 8'h00, tx_data);
            end
            prev_v = tx_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int n);
        logic [7:0] b[5];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
        for (int i = 0; i < n; i++) send_byte(b[i]);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check(name, exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_wr_en"}, reg_wr_en, 0);
        check({tag, "_rd_en"}, reg_rd_en, 0);
        check({tag, "_addr"}, reg_addr, 0);
        check({tag, "_wr_data"}, reg_wr_data, 0);
        check({tag, "_err"}, err_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] junk[4];
        int i;
        junk[0] = 8'hA5; junk[1] = 8'h52; junk[2] = 8'h20; junk[3] = 8'h72;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Write
        push(K_WR, 8'h10, 8'h3C); push(K_TX, 8'h00, 8'h06);
        send_frame(8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B, 5);
        drain("drain_write");
        check("err_after_write", err_count, 0);
        check("idle_after_write", busy, 0);

        // Read
        rd_val = 8'h9E;
        push(K_RD, 8'h20, 8'h00); push(K_TX, 8'h00, 8'h9E);
        send_frame(8'hA5, 8'h52, 8'h20, 8'h72, 8'h00, 4);
        drain("drain_read");
        check("err_after_read", err_count, 0);

        // Bad checksum
        push(K_TX, 8'h00, 8'h15);
        send_frame(8'hA5, 8'h57, 8'h10, 8'h3C, 8'h00, 5);
        drain("drain_badchk");
        check("err_after_badchk", err_count, 1);

        // Hunt past junk, then bad opcode, then a normal read
        push(K_TX, 8'h00, 8'h15);
        send_frame(8'h00, 8'hFF, 8'hA5, 8'h41, 8'h00, 4);
        drain("drain_badop");
        check("err_after_badop", err_count, 2);
        rd_val = 8'h9E;
        push(K_RD, 8'h20, 8'h00); push(K_TX, 8'h00, 8'h9E);
        send_frame(8'hA5, 8'h52, 8'h20, 8'h72, 8'h00, 4);
        drain("drain_read2");
        check("err_after_read2", err_count, 2);

        // Timeout: last accepted byte, then TO idle cycles
        send_frame(8'hA5, 8'h57, 8'h00, 8'h00, 8'h00, 2);
        repeat (TO - 1) @(negedge clk);
        check("busy_before_expiry", busy, 1);
        @(negedge clk);
        check("busy_after_expiry", busy, 0);
        check("no_tx_on_timeout", tx_valid, 0);
        check("err_after_timeout", err_count, 3);

        // Byte arriving in the expiry cycle is consumed
        push(K_WR, 8'h10, 8'h3C); push(K_TX, 8'h00, 8'h06);
        send_frame(8'hA5, 8'h57, 8'h00, 8'h00, 8'h00, 2);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h10);
        send_byte(8'h3C);
        send_byte(8'h7B);
        drain("drain_edge_byte");
        check("err_after_edge_byte", err_count, 3);

        // Backpressure: response held 50 cycles, incoming bytes dropped
        tx_ready = 1'b0;
        push(K_WR, 8'h10, 8'h3C); push(K_TX, 8'h00, 8'h06);
        send_frame(8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B, 5);
        for (i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        check("tx_valid_rise", tx_valid, 1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rx_done = (k < 8) && (k % 2 == 0);
            rx_data = junk[(k / 2) % 4];
            check("hold_tx_valid", tx_valid, 1);
            check("hold_tx_data", tx_data, 8'h06);
        end
        rx_done = 1'b0;
        @(negedge clk);
        tx_ready = 1'b1;
        drain("drain_backpressure");
        check("err_after_backpressure", err_count, 3);

        // Reset mid-frame, then a clean read
        send_frame(8'hA5, 8'h57, 8'h10, 8'h00, 8'h00, 3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        rd_val = 8'h5A;
        push(K_RD, 8'h33, 8'h00); push(K_TX, 8'h00, 8'h5A);
        send_frame(8'hA5, 8'h52, 8'h33, 8'h61, 8'h00, 4);
        drain("drain_after_reset");
        check("err_after_reset_frame", err_count, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
